// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide controller.
package muldiv_pkg;

  localparam int unsigned DIV_CYCLES = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } ex_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StMul     = 3'd1,
    StDivIter = 3'd2,
    StFixup   = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/div_radix2_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step, MSB first.
module div_radix2_core #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] quotient_o,
  output logic [DW-1:0] remainder_o
);

  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;

  // Restoring step: shift next dividend bit into the remainder, keep the difference if it fits.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[DW-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      if (!diff[DW]) begin
        rem_d = diff[DW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        rem_d = shifted[DW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
    end
  end

  // Partial remainder / quotient / divisor registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO and stalls EX until commit.
module hilo_muldiv_ctrl #(
  parameter int unsigned DW         = 32,
  parameter int unsigned DIV_CYCLES = muldiv_pkg::DIV_CYCLES
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ex_start,
  input  logic [2:0]    ex_op,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          flush,
  output logic          stall_req,
  output logic          busy,
  output logic [DW-1:0] hi_rdata,
  output logic [DW-1:0] lo_rdata
);

  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(DIV_CYCLES);

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          mul_signed_q, mul_signed_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          div0_q, div0_d;

  ex_op_e          op;
  logic            div_signed;
  logic [DW-1:0]   div_a, div_b;
  logic            div_load, div_step;
  logic [DW-1:0]   quotient, remainder;
  logic [2*DW-1:0] ext_a, ext_b, product;

  assign op         = ex_op_e'(ex_op);
  assign div_signed = (op == OpDiv);
  // Signed divides run on magnitudes; signs are restored in FIXUP.
  assign div_a = (div_signed && rs_data[DW-1]) ? -rs_data : rs_data;
  assign div_b = (div_signed && rt_data[DW-1]) ? -rt_data : rt_data;

  // Sign-extending to 2*DW makes the truncated unsigned product equal the signed one.
  assign ext_a   = mul_signed_q ? {{DW{opa_q[DW-1]}}, opa_q} : {{DW{1'b0}}, opa_q};
  assign ext_b   = mul_signed_q ? {{DW{opb_q[DW-1]}}, opb_q} : {{DW{1'b0}}, opb_q};
  assign product = ext_a * ext_b;

  div_radix2_core #(
    .DW (DW)
  ) u_div (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (div_a),
    .divisor_i   (div_b),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  // FSM next state, HI/LO commit and stall request.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    mul_signed_d = mul_signed_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    div0_d       = div0_q;
    div_load     = 1'b0;
    div_step     = 1'b0;
    stall_req    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_start && !flush) begin
          case (op)
            OpMult, OpMultu: begin
              state_d      = StMul;
              opa_d        = rs_data;
              opb_d        = rt_data;
              mul_signed_d = (op == OpMult);
              stall_req    = 1'b1;
            end
            OpDiv, OpDivu: begin
              state_d   = StDivIter;
              qneg_d    = div_signed & (rs_data[DW-1] ^ rt_data[DW-1]);
              rneg_d    = div_signed & rs_data[DW-1];
              div0_d    = (rt_data == '0);
              cnt_d     = '0;
              div_load  = 1'b1;
              stall_req = 1'b1;
            end
            OpMthi:  hi_d = rs_data;
            OpMtlo:  lo_d = rs_data;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          {hi_d, lo_d} = product;
          state_d      = StDone;
          stall_req    = 1'b1;
        end
      end
      StDivIter: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          div_step  = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          stall_req = 1'b1;
          if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
            state_d = StFixup;
          end
        end
      end
      StFixup: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          // Divide-by-zero leaves remainder = |rs|; sign fixup turns it back into rs.
          lo_d      = div0_q ? DW'(DIV0_QUOT) : (qneg_q ? -quotient : quotient);
          hi_d      = rneg_q ? -remainder : remainder;
          state_d   = StDone;
          stall_req = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      mul_signed_q <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      div0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      mul_signed_q <= mul_signed_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      div0_q       <= div0_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with hand-computed expectations.
module tb_hilo_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_start = 1'b0;
  logic [2:0]  ex_op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        busy;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int stalls;

  hilo_muldiv_ctrl #(
    .DW         (32),
    .DIV_CYCLES (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ex_start  (ex_start),
    .ex_op     (ex_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .hi_rdata  (hi_rdata),
    .lo_rdata  (lo_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Holds the instruction in EX through the stall and the DONE cycle,
  // counting stalled cycles; returns at posedge+1 of the first cycle after completion.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    ex_start = 1'b1;
    ex_op    = op;
    rs_data  = a;
    rt_data  = b;
    n        = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!stall_req) break;
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    ex_start = 1'b0;
    ex_op    = OpNone;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_hi", hi_rdata, 32'h0);
    check("rst_lo", lo_rdata, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // MULT -2 * 3
    issue(OpMult, 32'hFFFF_FFFE, 32'd3, stalls);
    check("mult_stalls", stalls, 32'd2);
    check("mult_hi", hi_rdata, 32'hFFFF_FFFF);
    check("mult_lo", lo_rdata, 32'hFFFF_FFFA);
    check("mult_no_restart", {31'b0, busy}, 32'd0);

    // MULTU same operands
    issue(OpMultu, 32'hFFFF_FFFE, 32'd3, stalls);
    check("multu_hi", hi_rdata, 32'h0000_0002);
    check("multu_lo", lo_rdata, 32'hFFFF_FFFA);

    // DIV -7 / 2
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, stalls);
    check("div_stalls", stalls, 32'd34);
    check("div_lo", lo_rdata, 32'hFFFF_FFFD);
    check("div_hi", hi_rdata, 32'hFFFF_FFFF);
    check("div_no_restart", {31'b0, busy}, 32'd0);

    // DIVU 100 / 7
    issue(OpDivu, 32'd100, 32'd7, stalls);
    check("divu_lo", lo_rdata, 32'd14);
    check("divu_hi", hi_rdata, 32'd2);

    // DIVU by zero
    issue(OpDivu, 32'h1234, 32'd0, stalls);
    check("divu0_stalls", stalls, 32'd34);
    check("divu0_lo", lo_rdata, 32'hFFFF_FFFF);
    check("divu0_hi", hi_rdata, 32'h0000_1234);

    // Signed DIV by zero: HI returns rs unchanged
    issue(OpDiv, 32'hFFFF_FFFB, 32'd0, stalls);
    check("div0_lo", lo_rdata, 32'hFFFF_FFFF);
    check("div0_hi", hi_rdata, 32'hFFFF_FFFB);

    // Signed overflow wraps
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
    check("ovf_lo", lo_rdata, 32'h8000_0000);
    check("ovf_hi", hi_rdata, 32'h0);

    // MTHI then MTLO: no stall, one edge each
    issue(OpMthi, 32'hDEAD_BEEF, 32'd0, stalls);
    check("mthi_stalls", stalls, 32'd0);
    check("mthi_hi", hi_rdata, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo_rdata, 32'h8000_0000);
    issue(OpMtlo, 32'h0BAD_F00D, 32'd0, stalls);
    check("mtlo_stalls", stalls, 32'd0);
    check("mtlo_lo", lo_rdata, 32'h0BAD_F00D);
    check("mtlo_hi_kept", hi_rdata, 32'hDEAD_BEEF);

    // Flush a DIVU at iteration 10
    ex_start = 1'b1;
    ex_op    = OpDivu;
    rs_data  = 32'd100;
    rt_data  = 32'd7;
    @(posedge clk);
    #1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    ex_start = 1'b0;
    flush    = 1'b1;
    #1;
    check("flush_stall_in_cycle", {31'b0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    check("flush_stall_after", {31'b0, stall_req}, 32'd0);
    check("flush_hi_kept", hi_rdata, 32'hDEAD_BEEF);
    check("flush_lo_kept", lo_rdata, 32'h0BAD_F00D);

    // MULT after flush
    issue(OpMult, 32'd5, 32'd6, stalls);
    check("mult56_stalls", stalls, 32'd2);
    check("mult56_lo", lo_rdata, 32'd30);
    check("mult56_hi", hi_rdata, 32'd0);

    // Asynchronous reset during DIV_ITER
    ex_start = 1'b1;
    ex_op    = OpDivu;
    rs_data  = 32'd100;
    rt_data  = 32'd7;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    ex_start = 1'b0;
    check("arst_busy_before", {31'b0, busy}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_hi", hi_rdata, 32'h0);
    check("arst_lo", lo_rdata, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Operation after reset: MULTU max * max
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls);
    check("multu_max_hi", hi_rdata, 32'hFFFF_FFFE);
    check("multu_max_lo", lo_rdata, 32'h0000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
